// File: rtl/irrigation_zone_controller.sv
// Tank-level FSM gating a round-robin multi-zone irrigation scheduler with drip/sprinkle/agro cycles.
// Optional fill watchdog enabled by defining IRRIG_FILL_WATCHDOG_EN.
module irrigation_zone_controller #(
    parameter int NUM_ZONES     = 4,
    parameter int TIMER_W       = 8,
    parameter int DRIP_TIME     = 20,
    parameter int SPRINKLE_TIME = 10,
    parameter int AGRO_TIME     = 5,
    parameter int FILL_TIMEOUT  = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         us,
    input  logic                         sc,
    input  logic                         fc,
    input  logic                         switch,
    input  logic                         ad,
    input  logic [NUM_ZONES-1:0]         zone_req,
    input  logic [NUM_ZONES-1:0]         zone_mode,
    output logic                         alarm,
    output logic                         inletValve,
    output logic                         outletValve,
    output logic                         sprinkling,
    output logic                         drip,
    output logic                         agrodefensiveSprinkler,
    output logic [NUM_ZONES-1:0]         zone_valve,
    output logic [$clog2(NUM_ZONES)-1:0] active_zone,
    output logic [1:0]                   tank_state
);

    localparam int IDX_W = $clog2(NUM_ZONES);

    typedef enum logic [1:0] {
        T_FILL  = 2'b00,
        T_READY = 2'b01,
        T_FAULT = 2'b10
    } tank_e;

    typedef enum logic [1:0] {
        I_IDLE     = 2'b00,
        I_IRRIGATE = 2'b01,
        I_AGRO     = 2'b10
    } irr_e;

    tank_e                tank_q, tank_d;
    irr_e                 irr_q, irr_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     az_q, az_d;
    logic [NUM_ZONES-1:0] zv_q, zv_d;
    logic                 inlet_q, inlet_d;
    logic                 alarm_q, alarm_d;
    logic                 outlet_q, outlet_d;
    logic                 sprk_q, sprk_d;
    logic                 drip_q, drip_d;
    logic                 agro_q, agro_d;

    logic                 valid;
    logic                 go;
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;

    // Sensors stack physically: a higher one wet implies every lower one wet.
    assign valid = ({fc, sc, us} == 3'b000) || ({fc, sc, us} == 3'b001) ||
                   ({fc, sc, us} == 3'b011) || ({fc, sc, us} == 3'b111);
    assign go    = switch & us & valid & (tank_q != T_FAULT);

`ifdef IRRIG_FILL_WATCHDOG_EN
    localparam int WD_W = $clog2(FILL_TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expired;

    assign wd_expired = (wd_q == WD_W'(FILL_TIMEOUT - 1));
`endif

    // Tank FSM; outputs are registered from the next state so they track tank_state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        tank_d = tank_q;
        unique case (tank_q)
            T_FILL: begin
                if (!valid)  tank_d = T_FAULT;
                else if (fc) tank_d = T_READY;
`ifdef IRRIG_FILL_WATCHDOG_EN
                else if (wd_expired) tank_d = T_FAULT;
`endif
            end
            T_READY: begin
                if (!valid)  tank_d = T_FAULT;
                else if (!sc) tank_d = T_FILL;
            end
            T_FAULT: begin
`ifdef IRRIG_FILL_WATCHDOG_EN
                if (valid && fc) tank_d = T_FILL;
`else
                if (valid) tank_d = T_FILL;
`endif
            end
            default: tank_d = T_FILL;
        endcase
        inlet_d = (tank_d == T_FILL);
        alarm_d = ~us | (tank_d == T_FAULT);
    end

`ifdef IRRIG_FILL_WATCHDOG_EN
    // Counter restarts whenever FILL is (re)entered.
    assign wd_d = (tank_q == T_FILL && tank_d == T_FILL) ? wd_q + 1'b1 : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`endif

    // First requesting zone at or after the round-robin pointer, wrapping.
    always_comb begin
        int j;
        j           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_ZONES) j = j - NUM_ZONES;
            if (!grant_found && zone_req[IDX_W'(j)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

    // Irrigation FSM; request inputs are only looked at in IDLE.
    always_comb begin
        irr_d   = irr_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        az_d    = az_q;
        zv_d    = zv_q;
        sprk_d  = sprk_q;
        drip_d  = drip_q;
        agro_d  = agro_q;
        unique case (irr_q)
            I_IDLE: begin
                zv_d   = '0;
                az_d   = '0;
                sprk_d = 1'b0;
                drip_d = 1'b0;
                agro_d = 1'b0;
                if (go && ad) begin
                    irr_d   = I_AGRO;
                    timer_d = TIMER_W'(AGRO_TIME);
                    zv_d    = '1;
                    agro_d  = 1'b1;
                end else if (go && grant_found) begin
                    irr_d   = I_IRRIGATE;
                    az_d    = grant_idx;
                    zv_d    = NUM_ZONES'(1) << grant_idx;
                    drip_d  = zone_mode[grant_idx];
                    sprk_d  = ~zone_mode[grant_idx];
                    timer_d = zone_mode[grant_idx] ? TIMER_W'(DRIP_TIME) : TIMER_W'(SPRINKLE_TIME);
                end
            end
            I_IRRIGATE, I_AGRO: begin
                if (!go || timer_q == TIMER_W'(1)) begin
                    // Only a completed zone cycle advances the pointer; aborts re-serve the same zone.
                    if (go && irr_q == I_IRRIGATE)
                        ptr_d = (az_q == IDX_W'(NUM_ZONES - 1)) ? '0 : az_q + 1'b1;
                    irr_d   = I_IDLE;
                    timer_d = '0;
                    az_d    = '0;
                    zv_d    = '0;
                    sprk_d  = 1'b0;
                    drip_d  = 1'b0;
                    agro_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: irr_d = I_IDLE;
        endcase
        outlet_d = (irr_d != I_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tank_q   <= T_FILL;
            irr_q    <= I_IDLE;
            timer_q  <= '0;
            ptr_q    <= '0;
            az_q     <= '0;
            zv_q     <= '0;
            inlet_q  <= 1'b0;
            alarm_q  <= 1'b0;
            outlet_q <= 1'b0;
            sprk_q   <= 1'b0;
            drip_q   <= 1'b0;
            agro_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            tank_q   <= tank_d;
            irr_q    <= irr_d;
            timer_q  <= timer_d;
            ptr_q    <= ptr_d;
            az_q     <= az_d;
            zv_q     <= zv_d;
            inlet_q  <= inlet_d;
            alarm_q  <= alarm_d;
            outlet_q <= outlet_d;
            sprk_q   <= sprk_d;
            drip_q   <= drip_d;
            agro_q   <= agro_d;
        end
    end

    assign alarm                  = alarm_q;
    assign inletValve             = inlet_q;
    assign outletValve            = outlet_q;
    assign sprinkling             = sprk_q;
    assign drip                   = drip_q;
    assign agrodefensiveSprinkler = agro_q;
    assign zone_valve             = zv_q;
    assign active_zone            = az_q;
    assign tank_state             = tank_q;

endmodule

// File: tb/tb_irrigation_zone_controller.sv
// Directed self-checking bench for irrigation_zone_controller (default build, 4 zones).
module tb_irrigation_zone_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       us, sc, fc, sw, ad;
    logic [3:0] zone_req, zone_mode;
    logic       alarm, inletValve, outletValve, sprinkling, drip, agro;
    logic [3:0] zone_valve;
    logic [1:0] active_zone;
    logic [1:0] tank_state;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    always #5 clock = ~clock;

    irrigation_zone_controller dut (
        .clock                  (clock),
        .reset                  (reset),
        .us                     (us),
        .sc                     (sc),
        .fc                     (fc),
        .switch                 (sw),
        .ad                     (ad),
        .zone_req               (zone_req),
        .zone_mode              (zone_mode),
        .alarm                  (alarm),
        .inletValve             (inletValve),
        .outletValve            (outletValve),
        .sprinkling             (sprinkling),
        .drip                   (drip),
        .agrodefensiveSprinkler (agro),
        .zone_valve             (zone_valve),
        .active_zone            (active_zone),
        .tank_state             (tank_state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic sel_sig(input int s);
        case (s)
            0:       return drip;
            1:       return sprinkling;
            default: return agro;
        endcase
    endfunction

    // Length of a pulse that is already high on entry; bounded at 64 cycles.
    task automatic measure(input int s, output int len);
        len = 1;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (sel_sig(s)) len++;
            else break;
        end
    endtask

    task automatic set_sensors(input logic [2:0] fsu);
        {fc, sc, us} = fsu;
    endtask

    initial begin
        reset = 1'b1;
        set_sensors(3'b000);
        sw = 1'b0; ad = 1'b0; zone_req = '0; zone_mode = '0;
        repeat (2) tick();
        check("rst_tank", tank_state, 2'b00);
        check("rst_inlet", inletValve, 1'b0);
        check("rst_alarm", alarm, 1'b0);
        check("rst_zv", zone_valve, 4'b0000);
        check("rst_outlet", outletValve, 1'b0);

        reset = 1'b0;
        tick();
        check("empty_tank", tank_state, 2'b00);
        check("empty_inlet", inletValve, 1'b1);
        check("empty_alarm", alarm, 1'b1);
        check("empty_zv", zone_valve, 4'b0000);

        set_sensors(3'b111);
        tick();
        check("full_tank", tank_state, 2'b01);
        check("full_inlet", inletValve, 1'b0);
        check("full_alarm", alarm, 1'b0);

        // Zone 0 drip, then zone 2 sprinkle after one idle cycle.
        sw = 1'b1; zone_req = 4'b0101; zone_mode = 4'b0001;
        tick();
        check("z0_zv", zone_valve, 4'b0001);
        check("z0_drip", drip, 1'b1);
        check("z0_sprk", sprinkling, 1'b0);
        check("z0_outlet", outletValve, 1'b1);
        check("z0_az", active_zone, 2'd0);
        measure(0, n);
        check("z0_len", n, 20);
        check("gap_zv", zone_valve, 4'b0000);
        check("gap_outlet", outletValve, 1'b0);
        tick();
        check("z2_zv", zone_valve, 4'b0100);
        check("z2_sprk", sprinkling, 1'b1);
        check("z2_drip", drip, 1'b0);
        check("z2_az", active_zone, 2'd2);
        measure(1, n);
        check("z2_len", n, 10);

        // Zone 3 sprinkle with agro request held; agro follows, then wrap to zone 0.
        zone_req = 4'b1000; zone_mode = 4'b0000;
        tick();
        check("z3_zv", zone_valve, 4'b1000);
        check("z3_az", active_zone, 2'd3);
        ad = 1'b1; zone_req = 4'b0001; zone_mode = 4'b0001;
        measure(1, n);
        check("z3_len", n, 10);
        check("z3_end_agro", agro, 1'b0);
        tick();
        check("agro_on", agro, 1'b1);
        check("agro_zv", zone_valve, 4'b1111);
        check("agro_outlet", outletValve, 1'b1);
        ad = 1'b0;
        measure(2, n);
        check("agro_len", n, 5);
        tick();
        check("wrap_zv", zone_valve, 4'b0001);
        check("wrap_drip", drip, 1'b1);

        // Switch abort keeps the pointer: zone 0 is re-served with full duration.
        sw = 1'b0;
        tick();
        check("abort_zv", zone_valve, 4'b0000);
        check("abort_outlet", outletValve, 1'b0);
        sw = 1'b1; zone_req = 4'b0011;
        tick();
        check("reserve_zv", zone_valve, 4'b0001);
        measure(0, n);
        check("reserve_len", n, 20);

        // Zone 1 sprinkle, low water at its 4th cycle, then refill re-grants it.
        tick();
        check("z1_zv", zone_valve, 4'b0010);
        check("z1_sprk", sprinkling, 1'b1);
        repeat (3) tick();
        set_sensors(3'b000);
        tick();
        check("dry_zv", zone_valve, 4'b0000);
        check("dry_sprk", sprinkling, 1'b0);
        check("dry_outlet", outletValve, 1'b0);
        check("dry_alarm", alarm, 1'b1);
        check("dry_tank", tank_state, 2'b00);
        check("dry_inlet", inletValve, 1'b1);
        set_sensors(3'b111);
        tick();
        check("refill_zv", zone_valve, 4'b0010);
        check("refill_az", active_zone, 2'd1);
        check("refill_tank", tank_state, 2'b01);
        check("refill_alarm", alarm, 1'b0);
        measure(1, n);
        check("refill_len", n, 10);

        // Invalid sensor combination forces FAULT; a valid one returns to FILL.
        sw = 1'b0; zone_req = '0;
        set_sensors(3'b101);
        tick();
        check("fault_tank", tank_state, 2'b10);
        check("fault_alarm", alarm, 1'b1);
        check("fault_inlet", inletValve, 1'b0);
        set_sensors(3'b011);
        tick();
        check("unfault_tank", tank_state, 2'b00);
        check("unfault_inlet", inletValve, 1'b1);
        check("unfault_alarm", alarm, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
